// File: rtl/simple_st0_out_stage_pkg.sv
// Purpose: shared types and constants for the stage-0 output stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package simple_st0_out_stage_pkg;

  // 32-bit float sample: sign in bit 31, exponent and mantissa below.
  typedef logic [31:0] float_24_8;

  localparam int FLOAT_W     = 32;
  localparam int SIGN_BIT    = 31;
  localparam int BEAT_CNT_W  = 6;
  localparam int FIFO_WORD_W = FLOAT_W + 1;  // {fst, data}

endpackage

// File: rtl/simple_st0_out_fifo.sv
// Purpose: DEPTH-entry storage for {fst, data} words with occupancy count.
// Latency: a word written in cycle N is at rd_dat in cycle N+1.
// Backpressure: writes ignored when full, reads ignored when empty.
// Ports: clk/reset (sync, active-high); wr_en/wr_dat push; rd_en pop;
//        rd_dat is the head (zero when empty); count is current occupancy.
module simple_st0_out_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && (count != FULL_CNT);
  assign do_rd = rd_en && (count != '0);

  // Head is masked when empty so the output reads zero after reset
  // without needing to clear the storage array.
  assign rd_dat = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/simple_st0_out_stage.sv
// Purpose: buffers stage-0 samples toward stage 1 with optional ReLU and frame-length checking.
// Latency: 1 cycle from ingress accept to stage_1_data_vld into an empty FIFO.
// Backpressure: stage_0_data_out_rdy = not full, registered only; no path from stage_1_data_rdy.
// Ports: clk/reset (sync, active-high); stage_0_data_out* ingress handshake;
//        relu_enable, frame_length config; stage_1_data* egress handshake;
//        fifo_count occupancy; frame_error pulse and frame_error_sticky.
module simple_st0_out_stage
  import simple_st0_out_stage_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  float_24_8              stage_0_data_out,
  input  logic                   stage_0_data_out_fst,
  input  logic                   stage_0_data_out_vld,
  output logic                   stage_0_data_out_rdy,
  input  logic                   relu_enable,
  input  logic [5:0]             frame_length,
  output float_24_8              stage_1_data,
  output logic                   stage_1_data_fst,
  output logic                   stage_1_data_vld,
  input  logic                   stage_1_data_rdy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   frame_error,
  output logic                   frame_error_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic                   ingress;
  logic                   egress;
  float_24_8              ingress_data;
  logic [FIFO_WORD_W-1:0] head;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic                   violation;

  assign stage_0_data_out_rdy = (fifo_count != FULL_CNT);
  assign stage_1_data_vld     = (fifo_count != '0);

  // A beat presented during reset is never recorded.
  assign ingress = stage_0_data_out_vld && stage_0_data_out_rdy && !reset;
  assign egress  = stage_1_data_vld && stage_1_data_rdy;

  assign ingress_data = (relu_enable && stage_0_data_out[SIGN_BIT]) ? '0 : stage_0_data_out;

  assign {stage_1_data_fst, stage_1_data} = head;

  simple_st0_out_fifo #(
    .WIDTH (FIFO_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ingress),
    .wr_dat ({stage_0_data_out_fst, ingress_data}),
    .rd_en  (egress),
    .rd_dat (head),
    .count  (fifo_count)
  );

  // A new frame is legal only if the previous one was empty (counter 0) or
  // exactly frame_length long; a continuation beat past frame_length is an
  // overrun. frame_length=0 compares against the wrapped 64-beat count.
  always_comb begin
    violation = 1'b0;
    if (stage_0_data_out_fst) begin
      violation = (beat_cnt != '0) && (beat_cnt != frame_length);
    end else begin
      violation = (beat_cnt == frame_length);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt           <= '0;
      frame_error        <= 1'b0;
      frame_error_sticky <= 1'b0;
    end else begin
      frame_error <= ingress && violation;
      if (ingress && violation) begin
        frame_error_sticky <= 1'b1;
      end
      if (ingress) begin
        beat_cnt <= stage_0_data_out_fst ? BEAT_CNT_W'(1) : beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/simple_st0_out_stage.md
SIMPLE_ST0_OUT_STAGE -- requirements
Module: simple_st0_out_stage

Interface
REQ-001 The module SHALL have one parameter line: DEPTH, default 8, number of FIFO entries (power of two, at least 2).
REQ-002 The module SHALL have the port: clk  input  1  the single clock; all logic is rising-edge.
REQ-003 The module SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have the port: stage_0_data_out  input  float_24_8  upstream sample.
REQ-005 The module SHALL have the port: stage_0_data_out_fst  input  1  first beat of frame.
REQ-006 The module SHALL have the port: stage_0_data_out_vld  input  1  upstream valid.
REQ-007 The module SHALL have the port: stage_0_data_out_rdy  output  1  ready to accept.
REQ-008 The module SHALL have the port: relu_enable  input  1  apply ReLU on ingress.
REQ-009 The module SHALL have the port: frame_length  input  6  expected beats per frame (0 means 64).
REQ-010 The module SHALL have the port: stage_1_data  output  float_24_8  downstream sample.
REQ-011 The module SHALL have the port: stage_1_data_fst  output  1  first beat of frame.
REQ-012 The module SHALL have the port: stage_1_data_vld  output  1  downstream valid.
REQ-013 The module SHALL have the port: stage_1_data_rdy  input  1  downstream ready.
REQ-014 The module SHALL have the port: fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-015 The module SHALL have the port: frame_error  output  1  one-cycle pulse on frame-length violation.
REQ-016 The module SHALL have the port: frame_error_sticky  output  1  latched OR of frame_error.

Function
REQ-017 An ingress transfer SHALL occur on a cycle where stage_0_data_out_vld and stage_0_data_out_rdy are both high; an egress transfer SHALL occur where stage_1_data_vld and stage_1_data_rdy are both high.
REQ-018 stage_0_data_out_rdy SHALL equal (fifo_count < DEPTH), decoded only from registers, with no combinational path from stage_1_data_rdy.
REQ-019 On ingress, the stored word SHALL be {fst, data}; data SHALL be forced to 32'h0 when relu_enable=1 and bit 31 (sign) =1, and SHALL otherwise pass unchanged.
REQ-020 stage_1_data, stage_1_data_fst and stage_1_data_vld (= fifo_count != 0) SHALL reflect the FIFO head; a word accepted in cycle N SHALL be visible no earlier than cycle N+1 (latency 1 into an empty FIFO).
REQ-021 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order; read/write pointers SHALL wrap modulo DEPTH.
REQ-022 While stage_1_data_rdy=0, the outputs stage_1_data* SHALL hold stable.
REQ-023 The beat counter (6 bits) SHALL load 1 on an ingress beat with fst=1, and SHALL otherwise increment on each ingress beat, wrapping 63 to 0.
REQ-024 The module SHALL pulse frame_error for one cycle, the cycle after the ingress beat, when either (a) fst=1 arrives and the counter is nonzero and not equal to frame_length, or (b) fst=0 arrives while the counter equals frame_length (overrun).
REQ-025 frame_error_sticky SHALL set on frame_error and clear only on reset; data flow SHALL continue unchanged on error.

Reset
REQ-026 On reset=1 the module SHALL clear pointers, fifo_count, beat counter, frame_error and frame_error_sticky to 0, giving stage_1_data_vld=0, stage_0_data_out_rdy=1 in the following cycle, and stage_1_data=0, stage_1_data_fst=0.
REQ-027 Reset asserted mid-frame SHALL discard all buffered words, and no ingress transfer SHALL be recorded in a reset cycle.

Structure
REQ-028 float_24_8 SHALL come from the shared types package; no new typedefs SHALL be added; DEPTH SHALL be a module parameter.
REQ-029 Storage SHALL be one sub-module, simple_st0_out_fifo (33-bit wide, DEPTH deep, count output); ReLU, frame checking and handshake SHALL live in the top.

Verification
REQ-030 The bench SHALL cover: a 4-beat frame, fst on beat 1, frame_length=4, sink always ready -> 4 outputs in order, each 1 cycle after input, frame_error never high.
REQ-031 The bench SHALL cover: relu_enable=1 with inputs 32'hBF800000 and 32'h3F800000 -> outputs 32'h0 and 32'h3F800000.
REQ-032 The bench SHALL cover: sink rdy=0, source continuously valid -> after 8 accepts, stage_0_data_out_rdy=0 and fifo_count=8; then rdy=1 -> all 8 drained in order and pointers wrap correctly.
REQ-033 The bench SHALL cover: frame_length=4 with fst after 3 beats -> frame_error pulses 1 cycle and sticky=1; a 5th beat without fst -> frame_error pulses again.
REQ-034 The bench SHALL cover: reset asserted with fifo_count=5 -> next cycle vld=0, count=0, rdy=1, sticky=0.
REQ-035 The bench SHALL cover: random vld/rdy at 50% for 1000 beats -> scoreboard matches order and data, with no loss or duplication.
